ks_sub_pipe: RTL and testbench



---
 rtl/ks_pkg.sv | 27 ++
 rtl/ks_prefix_level.sv | 21 ++
 rtl/ks_sub_pipe.sv | 188 ++++++++++++++++++
 tb/tb_ks_sub_pipe.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/ks_pkg.sv
// Shared types and helpers for the pipelined Kogge-Stone subtractor.
package ks_pkg;

    localparam int unsigned KS_WIDTH  = 64;
    localparam int unsigned KS_STAGES = 2;

    // Ceiling log2 for elaboration-time sizing.
    function automatic int unsigned clog2(input int unsigned val);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((32'd1 << i) < val) begin
                r = 32'(i + 1);
            end
        end
        return r;
    endfunction

    localparam int unsigned LEVELS        = clog2(KS_WIDTH);
    localparam int unsigned LVL_PER_STAGE = LEVELS / KS_STAGES;

    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

endpackage

// File: rtl/ks_prefix_level.sv
// One combinational Kogge-Stone prefix level with the given span.
module ks_prefix_level
    import ks_pkg::*;
#(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned SPAN  = 1
) (
    input  gp_t [WIDTH-1:0] i_gp,
    output gp_t [WIDTH-1:0] o_gp
);

    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
        if (i >= int'(SPAN)) begin : g_comb
            assign o_gp[i].g = i_gp[i].g | (i_gp[i].p & i_gp[i-SPAN].g);
            assign o_gp[i].p = i_gp[i].p & i_gp[i-SPAN].p;
        end else begin : g_pass
            assign o_gp[i] = i_gp[i];
        end
    end

endmodule

// File: rtl/ks_sub_pipe.sv
// Pipelined Kogge-Stone subtractor: diff = a - b - bin with valid/ready on both sides.
// Define KS_SUB_CMP_EN to add registered eq / lt_u / lt_s compare outputs.
module ks_sub_pipe
    import ks_pkg::*;
#(
    parameter int unsigned WIDTH  = 64,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_bin,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_diff,
    output logic             o_bout,
`ifdef KS_SUB_CMP_EN
    output logic             o_eq,
    output logic             o_lt_u,
    output logic             o_lt_s,
`endif
    output logic             o_ovf
);

    localparam int unsigned LEVELS_W = clog2(WIDTH);
    localparam int unsigned LPS      = LEVELS_W / STAGES;
    localparam int unsigned LAST     = STAGES - 1;

    // Whole pipeline moves together whenever the output slot can be vacated.
    logic w_adv;
    assign w_adv      = ~o_out_valid | i_out_ready;
    assign o_in_ready = w_adv;

    // Values entering each stage: valid, half-sum, carry in, operand MSBs, prefix state.
    logic             w_sv  [STAGES];
    logic [WIDTH-1:0] w_hs  [STAGES];
    logic             w_cin [STAGES];
    logic             w_am  [STAGES];
    logic             w_bm  [STAGES];
    gp_t  [WIDTH-1:0] w_gp  [STAGES];
    gp_t  [WIDTH-1:0] w_lv  [LEVELS_W];

    logic [WIDTH-1:0] w_nb;
    gp_t  [WIDTH-1:0] w_seed;

    assign w_nb     = ~i_b;
    assign w_sv[0]  = i_in_valid;
    assign w_hs[0]  = i_a ^ w_nb;
    assign w_cin[0] = ~i_bin;
    assign w_am[0]  = i_a[WIDTH-1];
    assign w_bm[0]  = i_b[WIDTH-1];
    assign w_gp[0]  = w_seed;

    // Carry in is folded into bit 0 generate so the prefix G is the true carry out.
    always_comb begin
        for (int i = 0; i < int'(WIDTH); i++) begin
            w_seed[i].g = i_a[i] & w_nb[i];
            w_seed[i].p = w_hs[0][i];
        end
        w_seed[0].g = (i_a[0] & w_nb[0]) | (w_hs[0][0] & ~i_bin);
    end

    for (genvar l = 0; l < int'(LEVELS_W); l++) begin : g_lvl
        gp_t [WIDTH-1:0] w_lin;
        if ((l % LPS) == 0) begin : g_from_stage
            assign w_lin = w_gp[l / LPS];
        end else begin : g_chain
            assign w_lin = w_lv[l-1];
        end
        ks_prefix_level #(
            .WIDTH (WIDTH),
            .SPAN  (1 << l)
        ) u_lvl (
            .i_gp (w_lin),
            .o_gp (w_lv[l])
        );
    end

    // Intermediate register banks between groups of prefix levels.
    for (genvar s = 0; s < int'(STAGES) - 1; s++) begin : g_bank
        logic             r_sv;
        logic             r_cin;
        logic             r_am;
        logic             r_bm;
        logic [WIDTH-1:0] r_hs;
        gp_t  [WIDTH-1:0] r_gp;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_sv  <= 1'b0;
                r_cin <= 1'b0;
                r_am  <= 1'b0;
                r_bm  <= 1'b0;
                r_hs  <= '0;
                r_gp  <= '0;
            end else if (w_adv) begin
                r_sv  <= w_sv[s];
                r_cin <= w_cin[s];
                r_am  <= w_am[s];
                r_bm  <= w_bm[s];
                r_hs  <= w_hs[s];
                r_gp  <= w_lv[(s+1)*LPS-1];
            end
        end

        assign w_sv[s+1]  = r_sv;
        assign w_cin[s+1] = r_cin;
        assign w_am[s+1]  = r_am;
        assign w_bm[s+1]  = r_bm;
        assign w_hs[s+1]  = r_hs;
        assign w_gp[s+1]  = r_gp;
    end

    logic [WIDTH-1:0] w_fin_g;
    logic [WIDTH-1:0] w_fin_p;
    logic [WIDTH-1:0] w_carry;
    logic [WIDTH-1:0] w_diff;
    logic             w_bout;
    logic             w_ovf;
    logic             w_unused_p;

    always_comb begin
        w_fin_g = '0;
        w_fin_p = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            w_fin_g[i] = w_lv[LEVELS_W-1][i].g;
            w_fin_p[i] = w_lv[LEVELS_W-1][i].p;
        end
    end

    // c_0 is the carry in; c_i for i>0 is the group generate ending at bit i-1.
    assign w_carry    = {w_fin_g[WIDTH-2:0], w_cin[LAST]};
    assign w_diff     = w_hs[LAST] ^ w_carry;
    assign w_bout     = ~w_fin_g[WIDTH-1];
    assign w_ovf      = (w_am[LAST] ^ w_bm[LAST]) & (w_diff[WIDTH-1] ^ w_am[LAST]);
    assign w_unused_p = ^w_fin_p;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_diff;
    logic             r_bout;
    logic             r_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_diff      <= '0;
            r_bout      <= 1'b0;
            r_ovf       <= 1'b0;
        end else if (w_adv) begin
            r_out_valid <= w_sv[LAST];
            r_diff      <= w_diff;
            r_bout      <= w_bout;
            r_ovf       <= w_ovf;
        end
    end

    assign o_out_valid = r_out_valid;
    assign o_diff      = r_diff;
    assign o_bout      = r_bout;
    assign o_ovf       = r_ovf;

`ifdef KS_SUB_CMP_EN
    // All-bits group propagate is set exactly when a == b, independent of bin.
    logic r_eq;
    logic r_lt_u;
    logic r_lt_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_eq   <= 1'b0;
            r_lt_u <= 1'b0;
            r_lt_s <= 1'b0;
        end else if (w_adv) begin
            r_eq   <= w_fin_p[WIDTH-1];
            r_lt_u <= w_bout;
            r_lt_s <= w_diff[WIDTH-1] ^ w_ovf;
        end
    end

    assign o_eq   = r_eq;
    assign o_lt_u = r_lt_u;
    assign o_lt_s = r_lt_s;
`endif

endmodule

// File: tb/tb_ks_sub_pipe.sv
// Scoreboard bench for ks_sub_pipe: directed vectors, stall stream, mid-stream reset.
module tb_ks_sub_pipe;

    localparam int unsigned W  = 64;
    localparam int unsigned ST = 2;

    typedef struct {
        logic [W-1:0] d;
        logic         bo;
        logic         ov;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         i_in_valid = 1'b0;
    logic         o_in_ready;
    logic [W-1:0] i_a = '0;
    logic [W-1:0] i_b = '0;
    logic         i_bin = 1'b0;
    logic         o_out_valid;
    logic         i_out_ready = 1'b1;
    logic [W-1:0] o_diff;
    logic         o_bout;
    logic         o_ovf;

    int checks = 0;
    int errors = 0;
    int n_sent = 0;
    int n_out  = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    ks_sub_pipe #(.WIDTH(W), .STAGES(ST)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_in_valid  (i_in_valid),
        .o_in_ready  (o_in_ready),
        .i_a         (i_a),
        .i_b         (i_b),
        .i_bin       (i_bin),
        .o_out_valid (o_out_valid),
        .i_out_ready (i_out_ready),
        .o_diff      (o_diff),
        .o_bout      (o_bout),
        .o_ovf       (o_ovf)
    );

    task automatic chk(input string name, input logic [65:0] act, input logic [65:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        logic [W:0]   r;
        logic [W+1:0] s;
        exp_t e;
        r = {1'b0, a} - {1'b0, b} - 65'(bin);
        s = {{2{a[W-1]}}, a} - {{2{b[W-1]}}, b} - 66'(bin);
        e.d  = r[W-1:0];
        e.bo = r[W];
        e.ov = (s[W+1:W-1] != 3'b000) && (s[W+1:W-1] != 3'b111);
        return e;
    endfunction

    function automatic exp_t mk(input logic [W-1:0] d, input logic bo, input logic ov);
        exp_t e;
        e.d  = d;
        e.bo = bo;
        e.ov = ov;
        return e;
    endfunction

    // Monitor: pop and compare on every output transfer; also watch stall stability.
    logic [65:0] held;
    logic        held_v = 1'b0;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                held_v = 1'b0;
            end else begin
                if (held_v && o_out_valid)
                    chk("stall_hold", {o_bout, o_ovf, o_diff}, held);
                held_v = 1'b0;
                if (o_out_valid && !i_out_ready) begin
                    held   = {o_bout, o_ovf, o_diff};
                    held_v = 1'b1;
                end
                if (o_out_valid && i_out_ready) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL spurious_out actual=%0h required=no_output", o_diff);
                    end else begin
                        e = q.pop_front();
                        chk("diff", 66'(o_diff), 66'(e.d));
                        chk("bout", 66'(o_bout), 66'(e.bo));
                        chk("ovf",  66'(o_ovf),  66'(e.ov));
                        n_out++;
                    end
                end
            end
        end
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin, input exp_t e);
        int waitc;
        waitc = 0;
        @(negedge clk);
        i_a        = a;
        i_b        = b;
        i_bin      = bin;
        i_in_valid = 1'b1;
        #1;
        while (!o_in_ready && waitc < 100) begin
            @(negedge clk);
            #1;
            waitc++;
        end
        if (!o_in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual=in_ready_low required=accept");
            i_in_valid = 1'b0;
            return;
        end
        q.push_back(e);
        n_sent++;
        @(posedge clk);
        #1 i_in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (q.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        repeat (2) @(negedge clk);
        chk("drain_pending", 66'(q.size()), 66'(0));
    endtask

    logic [W-1:0] sa [8] = '{64'h0000000000000010, 64'hFFFFFFFFFFFFFFFF, 64'h7FFFFFFFFFFFFFFF,
                             64'h0123456789ABCDEF, 64'h0000000000000000, 64'h8000000000000000,
                             64'hDEADBEEFCAFEF00D, 64'h5555555555555555};
    logic [W-1:0] sb [8] = '{64'h0000000000000020, 64'h0000000000000001, 64'hFFFFFFFFFFFFFFFF,
                             64'h0123456789ABCDEF, 64'h0000000000000000, 64'h8000000000000000,
                             64'h1111111111111111, 64'hAAAAAAAAAAAAAAAA};
    logic         sc [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    initial begin
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 66'(o_out_valid), 66'(0));
        chk("rst_diff",      66'(o_diff),      66'(0));
        chk("rst_bout",      66'(o_bout),      66'(0));
        chk("rst_ovf",       66'(o_ovf),       66'(0));
        chk("rst_in_ready",  66'(o_in_ready),  66'(1));
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            #1 chk("idle_no_valid", 66'(o_out_valid), 66'(0));
        end

        // Directed vectors with hand-computed results.
        send(64'h5, 64'h3, 1'b0, mk(64'h2, 1'b0, 1'b0));
        send(64'h0, 64'h1, 1'b0, mk(64'hFFFFFFFFFFFFFFFF, 1'b1, 1'b0));
        send(64'h0, 64'h1, 1'b1, mk(64'hFFFFFFFFFFFFFFFE, 1'b1, 1'b0));
        send(64'h8000000000000000, 64'h1, 1'b0, mk(64'h7FFFFFFFFFFFFFFF, 1'b0, 1'b1));
        send(64'h631ff211631ff211, 64'h12356312faf2fcff, 1'b0, mk(64'h50ea8efe682cf512, 1'b0, 1'b0));
        send(64'h123456789ABCDEF0, 64'h123456789ABCDEF0, 1'b0, mk(64'h0, 1'b0, 1'b0));
        send(64'h0, 64'h0, 1'b1, mk(64'hFFFFFFFFFFFFFFFF, 1'b1, 1'b0));
        drain();

        // Back-to-back stream with a consumer stall.
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send(sa[i], sb[i], sc[i], model(sa[i], sb[i], sc[i]));
            end
            begin
                repeat (3) @(negedge clk);
                i_out_ready = 1'b0;
                repeat (2) @(negedge clk);
                #1 chk("stall_in_ready", 66'(o_in_ready), 66'(0));
                repeat (3) @(negedge clk);
                i_out_ready = 1'b1;
            end
        join
        drain();
        chk("stream_count", 66'(n_out), 66'(n_sent));

        // Reset with two ops in flight.
        send(64'h100, 64'h1, 1'b0, mk(64'hFF, 1'b0, 1'b0));
        send(64'h200, 64'h2, 1'b0, mk(64'h1FE, 1'b0, 1'b0));
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 66'(o_out_valid), 66'(0));
        chk("midrst_diff",      66'(o_diff),      66'(0));
        chk("midrst_bout",      66'(o_bout),      66'(0));
        q.delete();
        n_sent = n_out;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        send(64'hA, 64'hA, 1'b0, mk(64'h0, 1'b0, 1'b0));
        for (int k = 1; k < int'(ST); k++) begin
            chk("lat_early", 66'(o_out_valid), 66'(0));
            @(posedge clk);
            #1;
        end
        chk("lat_hit", 66'(o_out_valid), 66'(1));
        drain();
        repeat (5) @(negedge clk);
        chk("final_count", 66'(n_out), 66'(n_sent));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
